// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: eight-digit multiplexed 7-segment driver for active-low
// common-anode displays, with hex decode, per-digit blink, decimal points
// and one blank cycle per digit slot.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         asynchronous reset, active low
//   EN          allows the input snapshot to load at a frame boundary
//   Disp_num    hex value, digit d shows Disp_num[4d+3:4d]
//   LE_out      blink mask, bit d = 1 makes digit d blink
//   point_out   point mask, bit d = 1 lights the dp of digit d
//   AN          digit enables, active low, AN[d] selects digit d
//   SEGMENT     segments, active low, [7]=dp, [6:0]=g,f,e,d,c,b,a
//   frame_start one-cycle pulse at the start of each frame
//   blink_phase 0 = blinking digits visible, 1 = blanked
module seg7_scan_drv #(
    parameter int SCAN_CNT     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  LE_out,
    input  logic [7:0]  point_out,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_start,
    output logic        blink_phase
);

    localparam int CW = $clog2(SCAN_CNT);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CNT - 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    digit_q, digit_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          blink_q, blink_d;
    logic [31:0]   disp_q, disp_d;
    logic [7:0]    le_q, le_d;
    logic [7:0]    pt_q, pt_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fs_q, fs_d;

    logic          tick;
    logic          fb;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = (cnt_q == CNT_MAX);
        fb      = tick && (digit_q == 3'd7);
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        digit_d = tick ? digit_q + 3'd1 : digit_q;

        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        if (fb) begin
            if (fcnt_q == FCNT_MAX) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // Inputs are only looked at on a frame boundary so a frame is
        // always drawn from one consistent snapshot.
        disp_d = disp_q;
        le_d   = le_q;
        pt_d   = pt_q;
        if (fb && EN) begin
            disp_d = Disp_num;
            le_d   = LE_out;
            pt_d   = point_out;
        end

        fs_d = fb;

        nib = disp_q[{digit_q, 2'b00} +: 4];
        // Slot cycle 0 is dark on every anode so the previous digit's
        // segments never ghost onto the newly selected one.
        if (cnt_q == '0) begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
        end else begin
            an_d = ~(8'b1 << digit_q);
            if (blink_q && le_q[digit_q]) begin
                seg_d = 8'hFF;
            end else begin
                seg_d = {~pt_q[digit_q], hex7(nib)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            digit_q <= '0;
            fcnt_q  <= '0;
            blink_q <= 1'b0;
            disp_q  <= '0;
            le_q    <= '0;
            pt_q    <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
            fs_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
            disp_q  <= disp_d;
            le_q    <= le_d;
            pt_q    <= pt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
        end
    end

    assign AN          = an_q;
    assign SEGMENT     = seg_q;
    assign frame_start = fs_q;
    assign blink_phase = blink_q;

endmodule
